// File: rtl/spi_pkg.sv
// Shared SPI definitions for the byte link between the on-chip master and the AES-side responder.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_WIDTH = 8;

  // sclk idles low; data launched after the rise, captured on the fall
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b1;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-level handshake between the responder and the AES loaders.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);
  logic             cs;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             done;
  logic             busy;
  logic             aborted;

  modport slave (
    input  cs, sclk, mosi, tx_data,
    output miso, rx_data, done, busy, aborted
  );

  modport master (
    output cs, sclk, mosi, tx_data,
    input  miso, rx_data, done, busy, aborted
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Optional 2-flop synchronizer, delayed copy and rise/fall pulses for one SPI pin.
// Define SPI_SLAVE_SYNC_EN to insert the synchronizer for an asynchronous master.
module spi_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic w_level;
  logic r_dly;

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_sig};
  end

  assign w_level = r_sync[1];
`else
  assign w_level = i_sig;
`endif

  // Reset to 0 so a cs already low when reset releases is not taken as a fall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_dly <= 1'b0;
    else          r_dly <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = ~r_dly & w_level;
  assign o_fall  = r_dly & ~w_level;
endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI responder: MSB-first shift in on mosi, shift out on miso, back-to-back frames.
// Build option SPI_SLAVE_SYNC_EN adds input synchronizers (3-clk detection latency).
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  spi_state_e       r_state,    w_state;
  logic [WIDTH-1:0] r_tx_shift, w_tx_shift;
  logic [WIDTH-1:0] r_rx_shift, w_rx_shift;
  logic [WIDTH-1:0] r_rx_data,  w_rx_data;
  logic [CW-1:0]    r_count,    w_count;
  logic             r_miso,     w_miso;
  logic             r_done,     w_done;
  logic             r_aborted,  w_aborted;

  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_edge_sync u_cs_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(bus.cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_edge_sync u_sclk_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(bus.sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_edge_sync u_mosi_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(bus.mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_cs_level, w_sclk_level, w_sclk_rise, w_mosi_rise, w_mosi_fall};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_count    <= '0;
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tx_shift <= w_tx_shift;
      r_rx_shift <= w_rx_shift;
      r_rx_data  <= w_rx_data;
      r_count    <= w_count;
      r_miso     <= w_miso;
      r_done     <= w_done;
      r_aborted  <= w_aborted;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tx_shift = r_tx_shift;
    w_rx_shift = r_rx_shift;
    w_rx_data  = r_rx_data;
    w_count    = r_count;
    w_miso     = r_miso;
    w_done     = 1'b0;
    w_aborted  = 1'b0;
    case (r_state)
      IDLE: begin
        w_miso = 1'b0;
        if (w_cs_fall) begin
          w_tx_shift = bus.tx_data;
          w_miso     = bus.tx_data[WIDTH-1];
          w_count    = '0;
          w_state    = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          // A deselect coinciding with the final fall still commits the frame
          w_state = IDLE;
          w_miso  = 1'b0;
          w_count = '0;
          if (w_sclk_fall && (r_count == LAST)) begin
            w_rx_data = {r_rx_shift[WIDTH-2:0], w_mosi};
            w_done    = 1'b1;
          end else if (r_count != '0) begin
            w_aborted = 1'b1;
          end
        end else if (w_sclk_fall) begin
          w_rx_shift = {r_rx_shift[WIDTH-2:0], w_mosi};
          if (r_count == LAST) begin
            w_rx_data  = {r_rx_shift[WIDTH-2:0], w_mosi};
            w_done     = 1'b1;
            w_count    = '0;
            w_tx_shift = bus.tx_data;
            w_miso     = bus.tx_data[WIDTH-1];
          end else begin
            w_count    = r_count + 1'b1;
            w_miso     = r_tx_shift[WIDTH-2];
            w_tx_shift = {r_tx_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.miso    = r_miso;
  assign bus.rx_data = r_rx_data;
  assign bus.done    = r_done;
  assign bus.busy    = (r_state == SHIFT);
  assign bus.aborted = r_aborted;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: models the on-chip master's sclk/mosi/miso timing.
module tb_spi_slave;
`ifdef SPI_SLAVE_SYNC_EN
  localparam int HALF = 4;
  localparam int LAT  = 3;
`else
  localparam int HALF = 2;
  localparam int LAT  = 1;
`endif

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   overlap = 0;
  logic [7:0] mi;

  spi_slave_if #(.WIDTH(8)) bus ();

  spi_slave #(.WIDTH(8)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done)                done_cnt++;
    if (bus.aborted)             abort_cnt++;
    if (bus.done && bus.aborted) overlap++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives nbits MSB-first; returns in the timestep of the final sclk fall.
  task automatic send_bits(input logic [7:0] mo, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (HALF - 1) @(negedge clk);
      @(negedge clk) bus.sclk = 1'b1;
      @(negedge clk) bus.mosi = mo[7-i];
      repeat (HALF - 1) @(negedge clk);
      rx = {rx[6:0], bus.miso};
      bus.sclk = 1'b0;
    end
  endtask

  task automatic select();
    @(negedge clk) bus.cs = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic deselect();
    @(negedge clk) bus.cs = 1'b1;
    repeat (LAT + 1) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_data = 8'h00;
    #1;
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_busy", {7'd0, bus.busy}, 8'h00);
    check("reset_miso", {7'd0, bus.miso}, 8'h00);
    check("reset_done", {7'd0, bus.done}, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);

    // single frame
    bus.tx_data = 8'hA5;
    select();
    check("f1_busy", {7'd0, bus.busy}, 8'h01);
    send_bits(8'h3C, 8, mi);
    repeat (LAT) @(negedge clk);
    check("f1_done_pulse", {7'd0, bus.done}, 8'h01);
    check("f1_rx_data", bus.rx_data, 8'h3C);
    check("f1_miso_byte", mi, 8'hA5);
    @(negedge clk);
    check("f1_done_low", {7'd0, bus.done}, 8'h00);
    deselect();
    check("f1_busy_low", {7'd0, bus.busy}, 8'h00);
    check("f1_done_cnt", 8'(done_cnt), 8'd1);

    // back-to-back frames, tx_data changed after the first frame is loaded
    bus.tx_data = 8'h5A;
    select();
    bus.tx_data = 8'hC3;
    send_bits(8'h01, 8, mi);
    repeat (LAT) @(negedge clk);
    check("b2b1_done", {7'd0, bus.done}, 8'h01);
    check("b2b1_rx_data", bus.rx_data, 8'h01);
    check("b2b1_miso_byte", mi, 8'h5A);
    @(negedge clk);
    send_bits(8'hFF, 8, mi);
    repeat (LAT) @(negedge clk);
    check("b2b2_done", {7'd0, bus.done}, 8'h01);
    check("b2b2_rx_data", bus.rx_data, 8'hFF);
    check("b2b2_miso_byte", mi, 8'hC3);
    deselect();
    check("b2b_done_cnt", 8'(done_cnt), 8'd3);
    check("b2b_abort_cnt", 8'(abort_cnt), 8'd0);

    // abort after 4 bits
    bus.tx_data = 8'h12;
    select();
    send_bits(8'hF0, 4, mi);
    repeat (HALF) @(negedge clk);
    deselect();
    check("abort_cnt", 8'(abort_cnt), 8'd1);
    check("abort_no_done", 8'(done_cnt), 8'd3);
    check("abort_rx_kept", bus.rx_data, 8'hFF);
    check("abort_busy", {7'd0, bus.busy}, 8'h00);
    check("abort_miso", {7'd0, bus.miso}, 8'h00);
    bus.tx_data = 8'h33;
    select();
    send_bits(8'h81, 8, mi);
    repeat (LAT) @(negedge clk);
    check("post_abort_rx", bus.rx_data, 8'h81);
    check("post_abort_miso_byte", mi, 8'h33);
    deselect();

    // reset mid-frame
    bus.tx_data = 8'hFF;
    select();
    send_bits(8'hAA, 5, mi);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_busy", {7'd0, bus.busy}, 8'h00);
    check("rst_miso", {7'd0, bus.miso}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    check("rst_cs_low_no_start", {7'd0, bus.busy}, 8'h00);
    check("rst_no_done", 8'(done_cnt), 8'd4);
    check("rst_no_abort", 8'(abort_cnt), 8'd1);
    deselect();
    bus.tx_data = 8'hC0;
    select();
    send_bits(8'h7E, 8, mi);
    repeat (LAT) @(negedge clk);
    check("post_rst_rx", bus.rx_data, 8'h7E);
    check("post_rst_miso_byte", mi, 8'hC0);
    deselect();

    // sclk activity while deselected
    send_bits(8'h55, 8, mi);
    repeat (LAT + 2) @(negedge clk);
    check("idle_busy", {7'd0, bus.busy}, 8'h00);
    check("idle_miso_byte", mi, 8'h00);
    check("idle_rx_kept", bus.rx_data, 8'h7E);
    check("idle_done_cnt", 8'(done_cnt), 8'd5);

    // deselect coinciding with the final sclk fall still commits
    bus.tx_data = 8'h0F;
    select();
    send_bits(8'hE7, 8, mi);
    bus.cs = 1'b1;
    repeat (LAT) @(negedge clk);
    check("sim_done", {7'd0, bus.done}, 8'h01);
    check("sim_rx", bus.rx_data, 8'hE7);
    @(negedge clk);
    check("sim_busy", {7'd0, bus.busy}, 8'h00);
    check("sim_no_abort", 8'(abort_cnt), 8'd1);
    repeat (LAT + 2) @(negedge clk);

    // 0x96 / 0x69 frame
    bus.tx_data = 8'h69;
    select();
    send_bits(8'h96, 8, mi);
    repeat (LAT - 1) @(negedge clk);
    check("f96_done_early", {7'd0, bus.done}, 8'h00);
    @(negedge clk);
    check("f96_done", {7'd0, bus.done}, 8'h01);
    check("f96_rx", bus.rx_data, 8'h96);
    check("f96_miso_byte", mi, 8'h69);
    deselect();
    check("final_done_cnt", 8'(done_cnt), 8'd7);
    check("done_abort_overlap", 8'(overlap), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the byte-oriented SPI link driven by the team's SPI master.
- Monitors cs/sclk/mosi in the system clock domain, shifts a byte MSB-first on mosi into rx_data, and shifts tx_data out on miso at the same time.
- Supports back-to-back bytes while cs stays low.
- Sits on the AES core side of the link, feeding received bytes into the key/data loaders and returning result bytes.

Parameters:
- WIDTH, 8, bits per frame; the bit counter is clog2(WIDTH) bits.

Ports:
- clk  in  1  system clock; same clock as the SPI master unless SPI_SLAVE_SYNC_EN is defined
- reset  in  1  asynchronous reset, active low
- tx_data  in  WIDTH  byte returned to the master; sampled at each frame start
- rx_data  out  WIDTH  last complete byte received
- done  out  1  one-cycle pulse, rx_data valid
- busy  out  1  high while selected (cs low, as seen internally)
- aborted  out  1  one-cycle pulse when cs rises mid-frame
- cs  in  1  chip select, active low
- sclk  in  1  serial clock; idles low, rises at bit start
- mosi  in  1  serial data from master
- miso  out  1  serial data to master

Behaviour:
- Reset (reset=0, async): state=IDLE; rx_data=0, done=0, busy=0, aborted=0, miso=0; shift registers and bit counter=0.
- Edge detection:
  - cs_fall = cs_d & ~cs; cs_rise = ~cs_d & cs; sclk_fall = sclk_d & ~sclk.
  - cs_d and sclk_d are one-cycle registered copies; detection latency is 1 clk.
- Timing contract with the master (sclk period 4 clk: 2 high, 2 low):
  - Master updates mosi 1 clk after the sclk rise and samples miso 2 clk after the rise.
  - Slave samples mosi and advances miso on the detected sclk falling edge.
  - miso is therefore stable at least 1 clk before the master's sample point.
- States:
  - IDLE: miso=0, busy=0. On cs_fall: tx_shift<=tx_data, miso<=tx_data[WIDTH-1], count<=0, go SHIFT.
  - SHIFT: busy=1.
    - On sclk_fall: rx_shift<={rx_shift[WIDTH-2:0],mosi}; count<=count+1.
    - If count!=WIDTH-1: miso<=tx_shift[WIDTH-2]; tx_shift shifts left by 1, filled with 0.
    - If count==WIDTH-1 (last bit): rx_data<={rx_shift[WIDTH-2:0],mosi}; done<=1 for one clk; count<=0; tx_shift<=tx_data; miso<=tx_data[WIDTH-1] (next frame preloaded); stay in SHIFT.
    - On cs_rise: go IDLE; miso<=0. If count!=0, pulse aborted; rx_data and done are not updated.
- Simultaneous events:
  - cs_rise and sclk_fall in the same clk: cs_rise wins; the partial bit is discarded.
  - If that same sclk_fall completes the frame (count==WIDTH-1), the frame still commits: done pulses, aborted does not.
- cs high in IDLE: sclk and mosi are ignored.
- Reset asserted mid-frame: immediate return to reset values; no done, no aborted.
- After reset deasserts with cs already low: no frame starts until a fresh cs_fall.
- done and aborted never assert in the same cycle.

Optional Feature:
- Macro: SPI_SLAVE_SYNC_EN.
- Defined:
  - cs, sclk and mosi each pass through a 2-flop synchronizer before edge detection; detection latency is 3 clk.
  - sclk period must be ≥ 8 clk and the external master must tolerate 3-clk miso latency.
  - Use this for an asynchronous off-chip master.
- Undefined: inputs are used directly; latency is 1 clk, and the 4-clk sclk of the on-chip master is supported.

Decomposition:
- Package spi_pkg: state typedef (IDLE, SHIFT), default WIDTH constant, SPI mode constants shared with the master.
- One sub-module, spi_edge_sync: per-signal optional synchronizer, delayed copy, rise/fall pulse outputs; instantiated for cs and sclk, mosi uses sync only.

Test Plan:
- Single frame, tx_data=0xA5, master sends 0x3C → rx_data=0x3C with one done pulse 1 clk after the 8th sclk fall; master receives 0xA5.
- Two back-to-back frames, cs held low, master sends 0x01 then 0xFF, tx_data changed 0x5A→0xC3 between frames → done pulses twice with rx_data 0x01 then 0xFF; master receives 0x5A then 0xC3.
- cs raised after 4 bits → one aborted pulse, no done, rx_data keeps its prior value, miso=0, busy=0; next full frame 0x81 received correctly.
- reset pulsed low mid-frame (bit 5) → all outputs 0 immediately; no done or aborted; next frame (cs fall after reset) 0x7E received correctly.
- sclk toggling with cs high → no state change, busy=0, miso=0, no pulses.
- SPI_SLAVE_SYNC_EN build, sclk period 8 clk, master sends 0x96, tx_data=0x69 → rx_data=0x96, done 3 clk after the last sclk fall, miso sequence matches 0x69.
